// File: rtl/uart_rx_framer_pkg.sv
// Shared types and helpers for the 8N1 serial receive path.
// Imported by the framer top and its byte FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Elaboration-time ceiling log2, used for counter and pointer widths
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Host-facing receive interface: serial line in, FIFO read port and sticky error flags out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_serial_in;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_read_en;
  logic                 rx_empty;
  logic                 rx_full;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clear;

  modport slave (
    input  rx_serial_in, rx_read_en, err_clear,
    output rx_data_out, rx_empty, rx_full, frame_err, overrun
  );

  modport master (
    output rx_serial_in, rx_read_en, err_clear,
    input  rx_data_out, rx_empty, rx_full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_framer_fifo.sv
// Show-ahead synchronous byte FIFO; the head word is presented whenever non-empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 drop
);
  localparam int PW = clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic                 push_eff, pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign drop     = push & full & ~pop_eff;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty mux above keeps stale words off data_out.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 asynchronous receiver: synchroniser, mid-bit sampling FSM, sticky error flags,
// and a show-ahead byte FIFO toward the host.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int              TW       = clog2(CLKS_PER_BIT);
  localparam int              BW       = clog2(DATA_BITS);
  localparam logic [TW-1:0]   MID_T    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]   LAST_T   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1_q, rx_s_q;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, frame_evt, drop;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_s_q != UART_IDLE_LEVEL) state_d = START;
      end
      START: begin
        if (timer_q == MID_T) begin
          timer_d   = '0;
          bit_idx_d = '0;
          // A line that is high again at the start-bit centre was only a glitch
          state_d   = (rx_s_q == UART_IDLE_LEVEL) ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == LAST_T) begin
          timer_d            = '0;
          shreg_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == LAST_BIT) state_d   = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == LAST_T) begin
          timer_d   = '0;
          push      = rx_s_q;
          frame_evt = ~rx_s_q;
          state_d   = rx_s_q ? IDLE : BREAK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_s_q == UART_IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new error event outranks a coincident clear
    frame_err_d = frame_evt | (frame_err_q & ~bus.err_clear);
    overrun_d   = drop      | (overrun_q   & ~bus.err_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= UART_IDLE_LEVEL;
      rx_s_q      <= UART_IDLE_LEVEL;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      sync1_q     <= bus.rx_serial_in;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

  rx_byte_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg_d),
    .pop       (bus.rx_read_en),
    .data_out  (bus.rx_data_out),
    .empty     (bus.rx_empty),
    .full      (bus.rx_full),
    .drop      (drop)
  );

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: a baud model drives 8N1 frames, expected bytes are
// queued at send time and a monitor pops and compares whenever the FIFO is read.
module tb_uart_rx_framer;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
  // Clock edges from driving the start bit low to rx_empty falling:
  // 2 synchroniser stages + 1 IDLE decision, half a bit, DB data bits, one stop bit.
  localparam int LAT   = 3 + CPB / 2 + DB * CPB + CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) u_if();

  uart_rx_framer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         auto_read = 1'b0;
  bit         pop_req   = 1'b0;
  logic       exp_frame_err = 1'b0;
  logic       exp_overrun   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: reads the FIFO head and checks it against the scoreboard
  initial begin
    u_if.rx_read_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (pop_req || (auto_read && !u_if.rx_empty))) begin
        if (pop_req) check("head_present_for_forced_pop", u_if.rx_empty, 1'b0);
        pop_req = 1'b0;
        check("scoreboard_has_byte", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rx_data_out", u_if.rx_data_out, exp_q.pop_front());
        u_if.rx_read_en = 1'b1;
      end else begin
        u_if.rx_read_en = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    u_if.rx_serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, u_if.frame_err, exp_frame_err);
    check({tag, "_overrun"},   u_if.overrun,   exp_overrun);
  endtask

  // Baud model: start bit, DB data bits LSB first, stop bit; the line is left at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_push);
    @(negedge clk);
    if (pop_at_push) begin
      fork
        begin
          repeat (LAT - 1) @(posedge clk);
          #1 pop_req = 1'b1;
        end
      join_none
    end
    u_if.rx_serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      u_if.rx_serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    u_if.rx_serial_in = stop_bit;
    if (!stop_bit)                                  exp_frame_err = 1'b1;
    else if (exp_q.size() < DEPTH || pop_at_push)   exp_q.push_back(b);
    else                                            exp_overrun = 1'b1;
    repeat (CPB) @(negedge clk);
    check_flags("frame");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("empty_after_drain", u_if.rx_empty, 1'b1);
  endtask

  task automatic pulse_err_clear();
    @(negedge clk);
    u_if.err_clear = 1'b1;
    @(negedge clk);
    u_if.err_clear = 1'b0;
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    check_flags("after_clear");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},      u_if.rx_data_out, 8'h00);
    check({tag, "_empty"},     u_if.rx_empty,    1'b1);
    check({tag, "_full"},      u_if.rx_full,     1'b0);
    check({tag, "_frame_err"}, u_if.frame_err,   1'b0);
    check({tag, "_overrun"},   u_if.overrun,     1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    u_if.rx_serial_in = 1'b1;
    u_if.err_clear    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2 * CPB);

    // 1: single frame, latency and pop
    auto_read = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        cnt = 0;
        do begin
          @(posedge clk);
          #1 cnt++;
        end while (u_if.rx_empty && cnt < 400);
        check("t1_latency", cnt, LAT);
        check("t1_head", u_if.rx_data_out, 8'hA5);
      end
    join
    check("t1_empty_after_pop", u_if.rx_empty, 1'b1);

    // 2: short low glitch rejected, then a clean frame
    @(negedge clk);
    u_if.rx_serial_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * CPB);
    check("t2_glitch_no_push", u_if.rx_empty, 1'b1);
    check_flags("t2_glitch");
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_drain();

    // 3: framing error followed by a break, then recovery and clear
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    check("t3_break_empty", u_if.rx_empty, 1'b1);
    check_flags("t3_break");
    idle(2 * CPB);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_drain();
    pulse_err_clear();

    // 4: overfill without reads
    auto_read = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == DEPTH - 1) check("t4_full_after_16", u_if.rx_full, 1'b1);
    end
    check("t4_full_after_17", u_if.rx_full, 1'b1);
    auto_read = 1'b1;
    wait_drain();
    pulse_err_clear();

    // 5: full FIFO with a pop on the exact push cycle
    auto_read = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    check("t5_full_before", u_if.rx_full, 1'b1);
    send_frame(8'hEE, 1'b1, 1'b1);
    check("t5_full_after", u_if.rx_full, 1'b1);
    auto_read = 1'b1;
    wait_drain();

    // 6: reset in the middle of a frame with state to lose
    auto_read = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    idle(2 * CPB);
    check("t6_pre_head", u_if.rx_data_out, 8'h77);
    @(negedge clk);
    u_if.rx_serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.rx_serial_in = (i == 0);
      repeat (CPB) @(negedge clk);
    end
    u_if.rx_serial_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    u_if.rx_serial_in = 1'b1;
    exp_q.delete();
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    idle(2 * CPB);
    check("t6_no_partial_byte", u_if.rx_empty, 1'b1);
    auto_read = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    wait_drain();

    // Randomised bytes and inter-frame gaps
    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 40));
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    wait_drain();
    check_flags("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
